// File: rtl/pool_readout_ctrl.sv
// Readout sequencer for the pooled activation array: holds the array in finish mode,
// walks every row/word, and streams each word into the output SRAM under backpressure.
module pool_readout_ctrl #(
  parameter int OUTPUT_HEIGHT   = 8,
  parameter int OUTPUT_WIDTH    = 8,
  parameter int OUTPUT_SRAM_LEN = 4,
  parameter int BIN_LEN         = 8,
  localparam int WPR    = OUTPUT_WIDTH / OUTPUT_SRAM_LEN,
  localparam int ADDR_W = (OUTPUT_HEIGHT * WPR > 1) ? $clog2(OUTPUT_HEIGHT * WPR) : 1,
  localparam int ROW_W  = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1,
  localparam int COL_W  = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1,
  localparam int DATA_W = BIN_LEN * OUTPUT_SRAM_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_pool_type,
  input  logic [2:0]        cfg_pool_stride,
  input  logic [2:0]        cfg_pool_kernel,
  output logic              pool_finish,
  output logic [1:0]        pool_type,
  output logic [2:0]        pool_stride,
  output logic [2:0]        pool_kernel,
  output logic              sram_r_en,
  output logic [ROW_W-1:0]  sram_r,
  output logic [COL_W-1:0]  sram_c,
  input  logic [DATA_W-1:0] sram_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OUTPUT_HEIGHT - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WPR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_READ, S_CAPTURE, S_WRITE, S_DONE
  } state_t;

  state_t              state_q;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                last_word;

  logic                pool_finish_q, sram_r_en_q, wr_en_q, busy_q, done_q;
  logic [1:0]          pool_type_q;
  logic [2:0]          pool_stride_q, pool_kernel_q;
  logic [ROW_W-1:0]    sram_r_q;
  logic [COL_W-1:0]    sram_c_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_W-1:0] r,
                                                  input logic [WORD_W-1:0] w);
    return ADDR_W'(int'(r) * WPR + int'(w));
  endfunction

  function automatic logic [COL_W-1:0] word_col(input logic [WORD_W-1:0] w);
    return COL_W'(int'(w) * OUTPUT_SRAM_LEN);
  endfunction

  // Position of the word that follows the current one in row-major order.
  always_comb begin
    word_d = word_q + WORD_W'(1);
    row_d  = row_q;
    if (word_q == WORD_LAST) begin
      word_d = '0;
      row_d  = row_q + ROW_W'(1);
    end
  end

  assign last_word = (row_q == ROW_LAST) && (word_q == WORD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      word_q        <= '0;
      pool_finish_q <= 1'b0;
      pool_type_q   <= '0;
      pool_stride_q <= '0;
      pool_kernel_q <= '0;
      sram_r_en_q   <= 1'b0;
      sram_r_q      <= '0;
      sram_c_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pool_type_q   <= cfg_pool_type;
            pool_stride_q <= cfg_pool_stride;
            pool_kernel_q <= cfg_pool_kernel;
            row_q         <= '0;
            word_q        <= '0;
            busy_q        <= 1'b1;
            pool_finish_q <= 1'b1;
            state_q       <= S_SETTLE;
          end
        end
        // One idle cycle with finish high lets the pooled outputs settle before reading.
        S_SETTLE: begin
          sram_r_en_q <= 1'b1;
          sram_r_q    <= row_q;
          sram_c_q    <= word_col(word_q);
          state_q     <= S_READ;
        end
        S_READ: begin
          sram_r_en_q <= 1'b0;
          state_q     <= S_CAPTURE;
        end
        // Array read data is registered, so it is valid here, one cycle after the enable.
        S_CAPTURE: begin
          wr_data_q <= sram_out;
          wr_addr_q <= word_addr(row_q, word_q);
          wr_en_q   <= 1'b1;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_en_q <= 1'b0;
            if (last_word) begin
              done_q        <= 1'b1;
              busy_q        <= 1'b0;
              pool_finish_q <= 1'b0;
              state_q       <= S_DONE;
            end else begin
              row_q       <= row_d;
              word_q      <= word_d;
              sram_r_en_q <= 1'b1;
              sram_r_q    <= row_d;
              sram_c_q    <= word_col(word_d);
              state_q     <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pool_finish = pool_finish_q;
  assign pool_type   = pool_type_q;
  assign pool_stride = pool_stride_q;
  assign pool_kernel = pool_kernel_q;
  assign sram_r_en   = sram_r_en_q;
  assign sram_r      = sram_r_q;
  assign sram_c      = sram_c_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pool_readout_ctrl.sv
// Randomized bench for pool_readout_ctrl: a default-size instance checked against a
// row-major word model of the pooled array, plus a minimal 2x4 instance.
module tb_pool_readout_ctrl;

  logic        clock = 1'b0;
  logic        reset, start, s_start;
  logic [1:0]  cfg_type;
  logic [2:0]  cfg_stride, cfg_kernel;

  logic        pool_finish, sram_r_en, wr_en, wr_ready, busy, done;
  logic [1:0]  pool_type;
  logic [2:0]  pool_stride, pool_kernel, sram_r, sram_c;
  logic [3:0]  wr_addr;
  logic [31:0] sram_out, wr_data;

  logic        s_pool_finish, s_sram_r_en, s_wr_en, s_wr_ready, s_busy, s_done;
  logic [1:0]  s_pool_type;
  logic [2:0]  s_pool_stride, s_pool_kernel;
  logic [0:0]  s_sram_r, s_wr_addr;
  logic [1:0]  s_sram_c;
  logic [31:0] s_sram_out, s_wr_data;

  int n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  pool_readout_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_pool_type(cfg_type), .cfg_pool_stride(cfg_stride), .cfg_pool_kernel(cfg_kernel),
    .pool_finish(pool_finish), .pool_type(pool_type), .pool_stride(pool_stride),
    .pool_kernel(pool_kernel), .sram_r_en(sram_r_en), .sram_r(sram_r), .sram_c(sram_c),
    .sram_out(sram_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done)
  );

  pool_readout_ctrl #(.OUTPUT_HEIGHT(2), .OUTPUT_WIDTH(4), .OUTPUT_SRAM_LEN(4)) dut_s (
    .clock(clock), .reset(reset), .start(s_start),
    .cfg_pool_type(cfg_type), .cfg_pool_stride(cfg_stride), .cfg_pool_kernel(cfg_kernel),
    .pool_finish(s_pool_finish), .pool_type(s_pool_type), .pool_stride(s_pool_stride),
    .pool_kernel(s_pool_kernel), .sram_r_en(s_sram_r_en), .sram_r(s_sram_r), .sram_c(s_sram_c),
    .sram_out(s_sram_out), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .wr_ready(s_wr_ready), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pooled array: 8x8 activations, read port registered one cycle after the enable.
  logic [7:0] mem [8][8];

  always @(posedge clock)
    if (sram_r_en)
      for (int k = 0; k < 4; k++) sram_out[k*8 +: 8] <= mem[sram_r][int'(sram_c) + k];

  always @(posedge clock)
    if (s_sram_r_en) s_sram_out <= 32'hC0DE_0000 | 32'(s_sram_r) | (32'(s_sram_c) << 8);

  function automatic logic [31:0] exp_word(input int a);
    logic [31:0] w;
    int r, c0;
    r  = a / 2;
    c0 = (a % 2) * 4;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = mem[r][c0 + k];
    return w;
  endfunction

  task automatic fill_mem();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r][c] = 8'($urandom);
  endtask

  // Monitor state for the default instance.
  int          cyc_n = 0, n_xfer = 0, n_done = 0, done_cyc = -1, first_wr_cyc = -1, t_start = 0;
  bit          mon_stall = 0;
  logic [3:0]  prev_addr;
  logic [31:0] prev_data;
  logic [1:0]  exp_type;
  logic [2:0]  exp_stride, exp_kernel;
  logic [31:0] got_addr_q[$], got_data_q[$];
  bit          ready_rand = 0;

  always @(negedge clock) begin
    cyc_n++;
    if (reset) mon_stall = 0;
    else begin
      if (mon_stall) begin
        chk("stall_addr", 64'(wr_addr), 64'(prev_addr));
        chk("stall_data", 64'(wr_data), 64'(prev_data));
        chk("stall_wr_en", 64'(wr_en), 64'd1);
      end
      if (wr_en) begin
        chk("no_read_in_write", 64'(sram_r_en), 64'd0);
        chk("finish_in_write", 64'(pool_finish), 64'd1);
        if (first_wr_cyc < 0) first_wr_cyc = cyc_n;
      end
      if (busy) begin
        chk("cfg_type", 64'(pool_type), 64'(exp_type));
        chk("cfg_stride", 64'(pool_stride), 64'(exp_stride));
        chk("cfg_kernel", 64'(pool_kernel), 64'(exp_kernel));
      end
      if (wr_en && wr_ready) begin
        got_addr_q.push_back(32'(wr_addr));
        got_data_q.push_back(wr_data);
        n_xfer++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc_n;
        chk("done_after_all", 64'(n_xfer), 64'd16);
        chk("finish_at_done", 64'(pool_finish), 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      mon_stall = wr_en && !wr_ready;
      prev_addr = wr_addr;
      prev_data = wr_data;
    end
  end

  initial forever begin
    @(posedge clock);
    #2;
    if (ready_rand) wr_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input logic [1:0] t, input logic [2:0] s, input logic [2:0] k);
    got_addr_q.delete();
    got_data_q.delete();
    n_xfer = 0; n_done = 0; first_wr_cyc = -1; done_cyc = -1;
    exp_type = t; exp_stride = s; exp_kernel = k;
    cfg_type = t; cfg_stride = s; cfg_kernel = k;
    start = 1'b1;
    t_start = cyc_n + 1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && n_done == 0; i++) @(posedge clock);
    #1;
    chk(tag, 64'(n_done), 64'd1);
  endtask

  task automatic check_seq();
    chk("num_writes", 64'(got_addr_q.size()), 64'd16);
    foreach (got_addr_q[i]) begin
      chk("wr_addr_seq", 64'(got_addr_q[i]), 64'(i));
      chk("wr_data_seq", 64'(got_data_q[i]), 64'(exp_word(i)));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_finish"}, 64'(pool_finish), 64'd0);
    chk({tag, "_type"}, 64'(pool_type), 64'd0);
    chk({tag, "_stride"}, 64'(pool_stride), 64'd0);
    chk({tag, "_kernel"}, 64'(pool_kernel), 64'd0);
    chk({tag, "_r_en"}, 64'(sram_r_en), 64'd0);
    chk({tag, "_r"}, 64'(sram_r), 64'd0);
    chk({tag, "_c"}, 64'(sram_c), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [2:0]  s_r_seen[$];
    logic [2:0]  s_c_seen[$];
    logic [31:0] s_a_seen[$], s_d_seen[$];
    int          s_ndone;
    logic [1:0]  t2;
    logic [2:0]  st2, k2;

    reset = 1'b1; start = 1'b0; s_start = 1'b0;
    cfg_type = '0; cfg_stride = '0; cfg_kernel = '0;
    wr_ready = 1'b1; s_wr_ready = 1'b1;
    fill_mem();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    chk("s_reset_busy", 64'(s_busy), 64'd0);
    chk("s_reset_wr_en", 64'(s_wr_en), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Full readout, no backpressure.
    start_run(2'd0, 3'd2, 3'd2);
    wait_done(200, "done_nostall");
    chk("done_latency", 64'(done_cyc - t_start), 64'd50);
    chk("first_wr_latency", 64'(first_wr_cyc - t_start), 64'd4);
    check_seq();
    repeat (3) @(posedge clock); #1;
    chk("single_done", 64'(n_done), 64'd1);

    // Random backpressure, and a second start mid-readout that must be ignored.
    fill_mem();
    t2 = 2'($urandom); st2 = 3'($urandom); k2 = 3'($urandom);
    ready_rand = 1;
    start_run(t2, st2, k2);
    repeat (20) @(posedge clock); #1;
    cfg_type = ~t2; cfg_stride = ~st2; cfg_kernel = ~k2;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(1000, "done_stall");
    ready_rand = 0;
    wr_ready = 1'b1;
    check_seq();
    repeat (3) @(posedge clock); #1;
    chk("single_done_stall", 64'(n_done), 64'd1);

    // Reset while the 7th write is stalled.
    fill_mem();
    start_run(2'd1, 3'd3, 3'd3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sram_r_en && sram_r == 3'd3 && sram_c == 3'd0) break;
    end
    #1 wr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (wr_en) break;
    end
    chk("stalled_addr", 64'(wr_addr), 64'd6);
    chk("xfers_before_reset", 64'(n_xfer), 64'd6);
    #1 reset = 1'b1;
    @(negedge clock);
    check_zero("midrun_reset");
    #1 reset = 1'b0;
    wr_ready = 1'b1;
    repeat (10) @(posedge clock); #1;
    chk("no_done_after_reset", 64'(n_done), 64'd0);
    start_run(2'd3, 3'd1, 3'd4);
    wait_done(200, "done_restart");
    check_seq();

    // start coincident with reset.
    n_done = 0;
    reset = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_finish", 64'(pool_finish), 64'd0);
    chk("rst_start_r_en", 64'(sram_r_en), 64'd0);
    chk("rst_start_done", 64'(n_done), 64'd0);

    // Minimal 2x4 instance: one word per row, two rows.
    @(posedge clock); #1;
    s_start = 1'b1;
    @(posedge clock); #1;
    s_start = 1'b0;
    s_ndone = 0;
    for (int i = 0; i < 60 && s_ndone == 0; i++) begin
      @(negedge clock);
      if (s_sram_r_en) begin
        s_r_seen.push_back(3'(s_sram_r));
        s_c_seen.push_back(3'(s_sram_c));
      end
      if (s_wr_en && s_wr_ready) begin
        s_a_seen.push_back(32'(s_wr_addr));
        s_d_seen.push_back(s_wr_data);
      end
      if (s_done) s_ndone++;
    end
    chk("s_done", 64'(s_ndone), 64'd1);
    chk("s_num_writes", 64'(s_a_seen.size()), 64'd2);
    chk("s_num_reads", 64'(s_r_seen.size()), 64'd2);
    foreach (s_a_seen[i]) begin
      chk("s_wr_addr", 64'(s_a_seen[i]), 64'(i));
      chk("s_wr_data", 64'(s_d_seen[i]), 64'(32'hC0DE_0000 | 32'(i)));
    end
    foreach (s_r_seen[i]) begin
      chk("s_sram_r", 64'(s_r_seen[i]), 64'(i));
      chk("s_sram_c", 64'(s_c_seen[i]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
